hssi_tx_pkt_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that merges NUM_CH HSSI host-exerciser TX AXI-Stream channels onto one 64-bit AXI-S egress.
- The egress feeds a single shared HSSI port, or the single AXI-S VIP slave in reduced-runtime loopback benches.
- A grant is held for the whole packet, from first beat through the tlast beat.
- Egress tdest carries the source channel index, so the consumer can demultiplex.

---
 rtl/hssi_tx_pkt_arbiter_pkg.sv | 16 +
 rtl/hssi_tx_pkt_arbiter_rr_arbiter.sv | 31 +++
 rtl/hssi_tx_pkt_arbiter.sv | 134 +++++++++++++
 tb/tb_hssi_tx_pkt_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssi_tx_pkt_arbiter_pkg.sv
// Shared types and constants for the HSSI TX packet arbiter.
package hssi_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W = 16;

  // Channel index width; never below one bit so a 2-channel build still has a select.
  function automatic int ch_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hssi_tx_pkt_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping.
module rr_arbiter
  import hssi_arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [IDX_W-1:0]  gnt_idx
);

  always_comb begin
    int  idx;
    logic found;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_CH;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        gnt_oh[IDX_W'(idx)]  = 1'b1;
        gnt_idx              = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hssi_tx_pkt_arbiter.sv
// Packet-aware round-robin merge of NUM_CH AXI-S TX channels onto one egress;
// the grant is held from first beat through tlast and tdest names the source.
module hssi_tx_pkt_arbiter
  import hssi_arb_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 64,
  parameter int USER_W    = 12,
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = PKT_CNT_W,
  localparam int IDX_W    = ch_idx_w(NUM_CH),
  localparam int KEEP_W   = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         s_tvalid,
  output logic [NUM_CH-1:0]         s_tready,
  input  logic [NUM_CH*DATA_W-1:0]  s_tdata,
  input  logic [NUM_CH*KEEP_W-1:0]  s_tkeep,
  input  logic [NUM_CH*USER_W-1:0]  s_tuser,
  input  logic [NUM_CH-1:0]         s_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic [USER_W-1:0]         m_tuser,
  output logic                      m_tlast,
  output logic [IDX_W-1:0]          m_tdest,
  output logic                      oversize_err,
  output logic [NUM_CH*CNT_W-1:0]   pkt_cnt,
  output arb_state_e                dbg_state
);

  localparam int BC_W = $clog2(MAX_BEATS + 2);
  localparam logic [BC_W-1:0] BC_SAT = BC_W'(MAX_BEATS + 1);

  // Handshake: a beat transfers on a rising clk edge where valid && ready.
  // valid never waits on ready, and payload is held while valid && !ready.

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, grant_q, next_ptr;
  logic [BC_W-1:0]   beat_cnt_q, beat_inc;
  logic [NUM_CH-1:0] arb_oh;
  logic [IDX_W-1:0]  arb_idx;
  logic              in_fire, in_last;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req     (s_tvalid),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  assign dbg_state = state_q;
  assign in_last   = s_tlast[grant_q];
  assign beat_inc  = (beat_cnt_q == BC_SAT) ? BC_SAT : beat_cnt_q + BC_W'(1);
  assign next_ptr  = (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    s_tready = '0;
    in_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_oh) state_d = BUSY;
      end
      BUSY: begin
        s_tready[grant_q] = !m_tvalid || m_tready;
        in_fire           = s_tvalid[grant_q] && (!m_tvalid || m_tready);
        if (in_fire && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |arb_oh) grant_q <= arb_idx;
      if (in_fire) begin
        if (in_last) begin
          beat_cnt_q <= '0;
          rr_ptr_q   <= next_ptr;
        end else begin
          beat_cnt_q <= beat_inc;
        end
      end
    end
  end

  // Single output register; a drain and a load on the same edge swap beats with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
      m_tdest  <= '0;
    end else if (in_fire) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata[int'(grant_q)*DATA_W +: DATA_W];
      m_tkeep  <= s_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
      m_tuser  <= s_tuser[int'(grant_q)*USER_W +: USER_W];
      m_tlast  <= in_last;
      m_tdest  <= grant_q;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // The beat that takes the count to MAX_BEATS+1 flags the packet, even if it is the tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oversize_err <= 1'b0;
      pkt_cnt      <= '0;
    end else if (in_fire) begin
      if (beat_inc == BC_SAT) oversize_err <= 1'b1;
      if (in_last) begin
        pkt_cnt[int'(grant_q)*CNT_W +: CNT_W] <=
          pkt_cnt[int'(grant_q)*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hssi_tx_pkt_arbiter.sv
// Directed bench for hssi_tx_pkt_arbiter: per-channel drivers, egress scoreboard, summary.
module tb_hssi_tx_pkt_arbiter;
  import hssi_arb_pkg::*;

  localparam int NUM_CH    = 8;
  localparam int DATA_W    = 64;
  localparam int USER_W    = 12;
  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 8;
  localparam int IDX_W     = 3;
  localparam int KEEP_W    = DATA_W / 8;
  localparam int EW        = IDX_W + 1 + KEEP_W + USER_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        s_tvalid = '0;
  logic [NUM_CH-1:0]        s_tready;
  logic [NUM_CH*DATA_W-1:0] s_tdata = '0;
  logic [NUM_CH*KEEP_W-1:0] s_tkeep = '0;
  logic [NUM_CH*USER_W-1:0] s_tuser = '0;
  logic [NUM_CH-1:0]        s_tlast = '0;
  logic                     m_tvalid;
  logic                     m_tready = 1'b0;
  logic [DATA_W-1:0]        m_tdata;
  logic [KEEP_W-1:0]        m_tkeep;
  logic [USER_W-1:0]        m_tuser;
  logic                     m_tlast;
  logic [IDX_W-1:0]         m_tdest;
  logic                     oversize_err;
  logic [NUM_CH*CNT_W-1:0]  pkt_cnt;
  arb_state_e               dbg_state;

  hssi_tx_pkt_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .USER_W(USER_W),
    .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .oversize_err(oversize_err), .pkt_cnt(pkt_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared state ----------------
  int chk = 0;
  int err = 0;
  logic [EW-1:0] exp_q[$];
  int n_pkts[NUM_CH];
  int pkt_len[NUM_CH];
  int cur_pkt[NUM_CH];
  int cur_beat[NUM_CH];
  int exp_cnt[NUM_CH];
  bit bp_mode = 0;
  bit gap_chk = 0;
  bit ovs_chk = 0;
  bit lat_arm = 0;
  int first_v = -1;
  int gap = -1;

  function automatic logic [DATA_W-1:0] beat_data(input int pkt, input int beat);
    return (64'(pkt) << 32) | (64'h11 * 64'(beat + 1));
  endfunction

  function automatic logic [EW-1:0] mk_exp(input int ch, input int pkt, input int beat, input int len);
    logic             last;
    logic [KEEP_W-1:0] keep;
    last = (beat == len - 1);
    keep = last ? 8'h0F : 8'hFF;
    return {IDX_W'(ch), last, keep, USER_W'((ch << 8) | beat), beat_data(pkt, beat)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int ch, input int pkt, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(mk_exp(ch, pkt, b, len));
  endtask

  task automatic load_ch(input int ch, input int npk, input int len);
    n_pkts[ch]   = npk;
    pkt_len[ch]  = len;
    cur_pkt[ch]  = 0;
    cur_beat[ch] = 0;
  endtask

  task automatic clear_chs();
    for (int c = 0; c < NUM_CH; c++) load_ch(c, 0, 1);
  endtask

  task automatic apply_drive(input int t);
    for (int c = 0; c < NUM_CH; c++) begin
      s_tvalid[c] = (cur_pkt[c] < n_pkts[c]);
      s_tlast[c]  = (cur_beat[c] == pkt_len[c] - 1);
      s_tdata[c*DATA_W +: DATA_W] = beat_data(cur_pkt[c], cur_beat[c]);
      s_tkeep[c*KEEP_W +: KEEP_W] = s_tlast[c] ? 8'h0F : 8'hFF;
      s_tuser[c*USER_W +: USER_W] = USER_W'((c << 8) | cur_beat[c]);
    end
    m_tready = bp_mode ? (t % 3 == 0) : 1'b1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_engine(input int budget, input int stop_fires);
    int  fires = 0;
    int  t     = 0;
    int  fch;
    bit  pend  = 1;
    while (pend && fires != stop_fires && t < budget) begin
      apply_drive(t);
      @(negedge clk);
      fch = -1;
      for (int c = 0; c < NUM_CH; c++) if (s_tvalid[c] && s_tready[c]) fch = c;
      @(posedge clk);
      #1;
      t++;
      if (fch >= 0) begin
        fires++;
        if (cur_beat[fch] == pkt_len[fch] - 1) begin
          cur_beat[fch] = 0;
          cur_pkt[fch]++;
          exp_cnt[fch]++;
        end else begin
          cur_beat[fch]++;
        end
      end
      pend = 0;
      for (int c = 0; c < NUM_CH; c++) if (cur_pkt[c] < n_pkts[c]) pend = 1;
    end
    chk++;
    assert (t < budget) else begin
      err++;
      $error("FAIL engine_budget: used %0d cycles, limit %0d", t, budget);
    end
    s_tvalid = '0;
    s_tlast  = '0;
  endtask

  task automatic drain(input string tag);
    s_tvalid = '0;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk++;
    assert (exp_q.size() === 0) else begin
      err++;
      $error("FAIL %s_beats_left: got %0d beats missing, exp 0", tag, exp_q.size());
    end
  endtask

  task automatic check_cnt(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      chk++;
      assert (pkt_cnt[c*CNT_W +: CNT_W] === CNT_W'(exp_cnt[c])) else begin
        err++;
        $error("FAIL %s_pkt_cnt[%0d]: got %0d exp %0d", tag, c,
               pkt_cnt[c*CNT_W +: CNT_W], CNT_W'(exp_cnt[c]));
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0]     got_v, exp_v;
  logic [DATA_W-1:0] prev_data;
  bit                stall_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
      gap        = -1;
    end else begin
      if (lat_arm && m_tvalid && first_v < 0) first_v = cyc;
      if (stall_prev) begin
        chk++;
        assert (m_tvalid === 1'b1 && m_tdata === prev_data) else begin
          err++;
          $error("FAIL stall_hold: got v=%b d=%h exp v=1 d=%h", m_tvalid, m_tdata, prev_data);
        end
      end
      if (m_tvalid && !m_tready) begin
        chk++;
        assert (s_tready === '0) else begin
          err++;
          $error("FAIL stall_ready: got s_tready=%b exp 0", s_tready);
        end
        stall_prev = 1;
        prev_data  = m_tdata;
      end else begin
        stall_prev = 0;
      end
      if (m_tvalid) begin
        if (gap_chk && gap >= 0) begin
          chk++;
          assert (gap === 1) else begin
            err++;
            $error("FAIL pkt_gap: got %0d idle cycles exp 1", gap);
          end
        end
        gap = -1;
      end else if (gap >= 0) begin
        gap++;
      end
      if (m_tvalid && m_tready) begin
        got_v = {m_tdest, m_tlast, m_tkeep, m_tuser, m_tdata};
        chk++;
        if (exp_q.size() == 0) begin
          err++;
          $error("FAIL egress_extra: got %h exp none", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          assert (got_v === exp_v) else begin
            err++;
            $error("FAIL egress_beat: got %h exp %h", got_v, exp_v);
          end
          if (ovs_chk && exp_v[EW-1 -: IDX_W] == '0) begin
            chk++;
            assert (oversize_err === (int'(exp_v[DATA_W +: 8]) >= MAX_BEATS)) else begin
              err++;
              $error("FAIL oversize_edge: beat %0d got %b exp %b", exp_v[DATA_W +: 8],
                     oversize_err, (int'(exp_v[DATA_W +: 8]) >= MAX_BEATS));
            end
          end
        end
        if (m_tlast) gap = 0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    clear_chs();
    for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk++; assert (m_tvalid === 1'b0) else begin err++; $error("FAIL rst_m_tvalid: got %b exp 0", m_tvalid); end
    chk++; assert ({m_tdata, m_tkeep, m_tuser, m_tlast, m_tdest} === '0) else begin
      err++; $error("FAIL rst_payload: got %h exp 0", {m_tdata, m_tkeep, m_tuser, m_tlast, m_tdest}); end
    chk++; assert (s_tready === '0) else begin err++; $error("FAIL rst_s_tready: got %b exp 0", s_tready); end
    chk++; assert (pkt_cnt === '0 && oversize_err === 1'b0) else begin
      err++; $error("FAIL rst_counters: got cnt=%h ovs=%b exp 0", pkt_cnt, oversize_err); end
    chk++; assert (dbg_state === IDLE) else begin err++; $error("FAIL rst_state: got %0d exp IDLE", dbg_state); end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All channels request 2-beat packets; ch0 has a second packet to show the wrap back to 0.
    clear_chs();
    for (int c = 0; c < NUM_CH; c++) begin
      load_ch(c, (c == 0) ? 2 : 1, 2);
      push_pkt(c, 0, 2);
    end
    push_pkt(0, 1, 2);
    gap = -1;
    gap_chk = 1;
    run_engine(200, -1);
    drain("rr");
    gap_chk = 0;
    check_cnt("rr");

    // Single 4-beat packet on ch3: first egress beat two cycles after s_tvalid rises.
    clear_chs();
    load_ch(3, 1, 4);
    push_pkt(3, 0, 4);
    first_v = -1;
    lat_arm = 1;
    begin
      int start_cyc;
      start_cyc = cyc;
      run_engine(50, -1);
      lat_arm = 0;
      chk++;
      assert (first_v - start_cyc === 2) else begin
        err++; $error("FAIL first_beat_latency: got %0d exp 2", first_v - start_cyc); end
    end
    drain("single");
    check_cnt("single");
    chk++; assert (dbg_state === IDLE) else begin err++; $error("FAIL idle_after_pkt: got %0d exp IDLE", dbg_state); end

    // Back-pressure: 6 beats on ch1 with m_tready cycling 1,0,0.
    clear_chs();
    load_ch(1, 1, 6);
    push_pkt(1, 0, 6);
    bp_mode = 1;
    run_engine(100, -1);
    bp_mode = 0;
    drain("bp");
    check_cnt("bp");

    // Oversize: 10 beats against MAX_BEATS=8, then a legal packet.
    chk++; assert (oversize_err === 1'b0) else begin err++; $error("FAIL ovs_pre: got %b exp 0", oversize_err); end
    clear_chs();
    load_ch(0, 1, 10);
    push_pkt(0, 0, 10);
    ovs_chk = 1;
    run_engine(100, -1);
    drain("ovs");
    ovs_chk = 0;
    chk++; assert (oversize_err === 1'b1) else begin err++; $error("FAIL ovs_set: got %b exp 1", oversize_err); end
    clear_chs();
    load_ch(6, 1, 2);
    push_pkt(6, 0, 2);
    run_engine(50, -1);
    drain("ovs_legal");
    chk++; assert (oversize_err === 1'b1) else begin err++; $error("FAIL ovs_sticky: got %b exp 1", oversize_err); end
    check_cnt("ovs");

    // Reset after beat 2 of a 5-beat packet on ch5, then a single-beat packet.
    clear_chs();
    load_ch(5, 1, 5);
    push_pkt(5, 0, 5);
    run_engine(50, 2);
    chk++; assert (m_tvalid === 1'b1) else begin err++; $error("FAIL pre_rst_valid: got %b exp 1", m_tvalid); end
    rst = 1'b1;
    #1;
    chk++; assert (m_tvalid === 1'b0 && s_tready === '0) else begin
      err++; $error("FAIL midrst_outputs: got v=%b rdy=%b exp 0", m_tvalid, s_tready); end
    chk++; assert (pkt_cnt === '0 && oversize_err === 1'b0) else begin
      err++; $error("FAIL midrst_counters: got cnt=%h ovs=%b exp 0", pkt_cnt, oversize_err); end
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_chs();
    load_ch(5, 1, 1);
    push_pkt(5, 0, 1);
    run_engine(50, -1);
    drain("post_rst");
    check_cnt("post_rst");

    // Counter wrap at the bench's reduced counter width.
    clear_chs();
    load_ch(2, 255, 1);
    for (int p = 0; p < 255; p++) push_pkt(2, p, 1);
    run_engine(1000, -1);
    drain("wrap_a");
    check_cnt("wrap_a");
    clear_chs();
    load_ch(2, 1, 1);
    push_pkt(2, 0, 1);
    run_engine(50, -1);
    drain("wrap_b");
    chk++; assert (pkt_cnt[2*CNT_W +: CNT_W] === '0) else begin
      err++; $error("FAIL wrap_zero: got %0d exp 0", pkt_cnt[2*CNT_W +: CNT_W]); end
    check_cnt("wrap_b");

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
